// File: rtl/yxn_cg_if.sv
// Handshake bundle for the Montgomery candidate generator:
// modulus load, operand in, candidate bank out.
interface yxn_cg_if #(
  parameter int NBITS = 8,
  parameter int PBITS = 1
);
  localparam int MLSIZE = 1 << PBITS;
  localparam int K      = MLSIZE / 2;
  localparam int W      = NBITS + PBITS + 2;

  logic                 n_load;
  logic [NBITS-1:0]     n_in;
  logic                 n_ready;
  logic                 in_valid;
  logic                 in_ready;
  logic [NBITS+PBITS:0] y_in;
  logic                 th_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         yxn [0:K];
  logic                 th_out;

  modport master (
    output n_load, n_in, in_valid, y_in, th_in, out_ready,
    input  n_ready, in_ready, out_valid, yxn, th_out
  );

  modport slave (
    input  n_load, n_in, in_valid, y_in, th_in, out_ready,
    output n_ready, in_ready, out_valid, yxn, th_out
  );
endinterface

// File: rtl/yxn_candidate_gen.sv
// Candidate bank yxn[k] = y - k*N for the Montgomery final
// reduction select; multiple table built serially on load.
module yxn_candidate_gen #(
  parameter int NBITS = 8,
  parameter int PBITS = 1
) (
  input logic     clk,
  input logic     rst,
  yxn_cg_if.slave bus
);
  localparam int MLSIZE = 1 << PBITS;
  localparam int K      = MLSIZE / 2;
  localparam int TB     = NBITS + PBITS + 1;
  localparam int W      = TB + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  state_t           state;
  logic [NBITS-1:0] n_reg;
  logic [PBITS-1:0] cnt;
  logic [TB-1:0]    tbl [0:K];

  logic             s1_valid;
  logic [TB-1:0]    s1_y;
  logic             s1_th;

  logic en;
  logic pipe_empty;
  logic n_acc;

  assign en          = !bus.out_valid | bus.out_ready;
  assign pipe_empty  = !s1_valid & !bus.out_valid;
  assign bus.n_ready = (state == IDLE)
                     | ((state == READY) & pipe_empty);
  assign bus.in_ready = (state == READY) & en;
  assign n_acc       = bus.n_load & bus.n_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n_reg <= '0;
      cnt   <= '0;
      for (int k = 0; k <= K; k++) tbl[k] <= '0;
    end else begin
      unique case (state)
        IDLE, READY: begin
          if (n_acc) begin
            n_reg  <= bus.n_in;
            cnt    <= PBITS'(1);
            tbl[0] <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          // one multiple per cycle: tbl[k] = tbl[k-1] + N
          tbl[cnt] <= tbl[cnt - 1'b1]
                    + {{(PBITS+1){1'b0}}, n_reg};
          cnt <= cnt + 1'b1;
          if (cnt == PBITS'(K)) state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_y          <= '0;
      s1_th         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.th_out    <= 1'b0;
      for (int k = 0; k <= K; k++) bus.yxn[k] <= '0;
    end else if (en) begin
      s1_valid      <= bus.in_valid & bus.in_ready;
      s1_y          <= bus.y_in;
      s1_th         <= bus.th_in;
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.th_out <= s1_th;
        // wraps mod 2^W so the MSB is the sign of y - k*N
        for (int k = 0; k <= K; k++)
          bus.yxn[k] <= {1'b0, s1_y} - {1'b0, tbl[k]};
      end
    end
  end
endmodule

// File: tb/tb_yxn_candidate_gen.sv
// Scoreboard bench for yxn_candidate_gen with NBITS=8, PBITS=2:
// directed load/stall cases plus randomized operand streams.
module tb_yxn_candidate_gen;
  localparam int K = 2;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yxn_cg_if #(.NBITS(8), .PBITS(2)) bus ();

  yxn_candidate_gen #(.NBITS(8), .PBITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int y;
    int n;
    bit th;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cur_n = 0;
  bit   rand_rdy = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // record every accepted operand with the modulus in force
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)
      q.push_back('{y: int'(bus.y_in), n: cur_n,
                    th: bus.th_in});
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !bus.out_ready)
        chk("in_ready_stall", 32'(bus.in_ready), 0);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bank got valid expected none");
        end else begin
          e = q[0];
          for (int k = 0; k <= K; k++) begin
            chk($sformatf("yxn%0d y=%0d n=%0d", k, e.y, e.n),
                32'(bus.yxn[k]), (e.y - k * e.n) & 32'hFFF);
            chk($sformatf("sign%0d", k),
                32'(bus.yxn[k][W-1]), 32'(e.y < k * e.n));
          end
          chk("th_out", 32'(bus.th_out), 32'(e.th));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready = ($urandom % 4) != 0;
  end

  task automatic send(int y, bit th);
    int budget;
    bus.in_valid = 1'b1;
    bus.y_in     = 11'(y);
    bus.th_in    = th;
    budget = 200;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      budget--;
      if (budget == 0) break;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no in_ready expected accept");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_n(int n);
    int budget;
    budget = 200;
    while (!bus.n_ready && budget > 0) begin
      tick();
      budget--;
    end
    chk("load_wait_n_ready", 32'(bus.n_ready), 1);
    bus.n_load = 1'b1;
    bus.n_in   = 8'(n);
    tick();
    bus.n_load = 1'b0;
    cur_n = n;
    chk("load_c1_n_ready", 32'(bus.n_ready), 0);
    chk("load_c1_in_ready", 32'(bus.in_ready), 0);
    tick();
    chk("load_c2_n_ready", 32'(bus.n_ready), 0);
    chk("load_c2_in_ready", 32'(bus.in_ready), 0);
    tick();
    chk("load_done_in_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((q.size() != 0 || bus.out_valid) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    bus.n_load    = 1'b0;
    bus.n_in      = '0;
    bus.in_valid  = 1'b0;
    bus.y_in      = '0;
    bus.th_in     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_n_ready", 32'(bus.n_ready), 1);
    chk("rst_in_ready", 32'(bus.in_ready), 0);

    // reset in the middle of a load
    bus.n_load = 1'b1;
    bus.n_in   = 8'd200;
    tick();
    bus.n_load = 1'b0;
    chk("midload_n_ready", 32'(bus.n_ready), 0);
    rst = 1'b1;
    #1;
    chk("rstload_out_valid", 32'(bus.out_valid), 0);
    chk("rstload_n_ready", 32'(bus.n_ready), 1);
    chk("rstload_in_ready", 32'(bus.in_ready), 0);
    chk("rstload_th_out", 32'(bus.th_out), 0);
    for (int k = 0; k <= K; k++)
      chk($sformatf("rstload_yxn%0d", k), 32'(bus.yxn[k]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 0);

    load_n(200);

    // latency: accept edge, one more edge, then valid
    bus.in_valid = 1'b1;
    bus.y_in     = 11'd450;
    bus.th_in    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("lat_c1_out_valid", 32'(bus.out_valid), 0);
    tick();
    chk("lat_c2_out_valid", 32'(bus.out_valid), 1);
    drain();

    send(150, 0);
    drain();

    // stream with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(int'($urandom_range(0, 2047)), 1'($urandom));
      end
      begin
        tick();
        tick();
        bus.out_ready = 1'b0;
        repeat (3) tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // modulus load with a full pipe must be ignored
    bus.out_ready = 1'b0;
    send(300, 1);
    send(100, 0);
    tick();
    chk("full_n_ready", 32'(bus.n_ready), 0);
    bus.n_load = 1'b1;
    bus.n_in   = 8'd5;
    tick();
    bus.n_load = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    drain();
    chk("after_ignore_in_ready", 32'(bus.in_ready), 1);

    load_n(0);
    send(77, 1);
    drain();

    rand_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      load_n(int'($urandom_range(0, 255)));
      for (int i = 0; i < 20; i++)
        send(int'($urandom_range(0, 2047)), 1'($urandom));
      drain();
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
